// File: rtl/hif_xbus_arb_pkg.sv
// Shared definitions for the host-interface xbus arbiter: widths, window limits,
// select/transaction state encodings, the latched-request payload and the window check.
package hif_xbus_arb_pkg;

  localparam int unsigned XBUS_ADDR_WIDTH = 7;
  localparam int unsigned XBUS_DATA_WIDTH = 8;
  localparam int unsigned WD_WIDTH        = 16;

  localparam logic [7:0]          MAX_NOR_REG_ADDR  = 8'h64;
  localparam logic [7:0]          MAX_TEST_REG_ADDR = 8'h65;
  localparam logic [WD_WIDTH-1:0] WD_CYCLES         = 16'd1000;

  // Select states double as the if_select codes.
  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_I2C  = 2'b01;
  localparam logic [1:0] SEL_SPI  = 2'b10;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_ADDR = 2'b01;
  localparam logic [1:0] T_XFER = 2'b10;
  localparam logic [1:0] T_ACK  = 2'b11;

  typedef struct packed {
    logic                       spi;
    logic                       wr;
    logic                       legal;
    logic [XBUS_ADDR_WIDTH-1:0] addr;
    logic [XBUS_DATA_WIDTH-1:0] wdata;
  } txn_t;

  // Zero-extended address compared against the normal/test register window.
  function automatic logic addr_legal(input logic [XBUS_ADDR_WIDTH-1:0] addr,
                                      input logic                       testmode_en);
    logic [7:0] a;
    a = 8'(addr);
    return !((a > MAX_TEST_REG_ADDR) || ((a > MAX_NOR_REG_ADDR) && !testmode_en));
  endfunction

endpackage

// File: rtl/hif_xbus_arb_sel_fsm.sv
// Interface select FSM: forced or first-activity auto lock of the xbus owner.
// Optional idle-release watchdog built when HIF_ARB_WD_EN is defined.
module hif_sel_fsm
  import hif_xbus_arb_pkg::*;
(
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       otp_done,
  input  logic       i2c_if,
  input  logic       spi_if,
  input  logic       i2c_active,
  input  logic       spi_csb,
  output logic [1:0] sel
);

  logic [1:0] sel_nxt;
  logic       i2c_active_q;
  logic       spi_csb_q;
  logic       i2c_rise;
  logic       spi_fall;

  assign i2c_rise = i2c_active & ~i2c_active_q;
  assign spi_fall = ~spi_csb & spi_csb_q;

`ifdef HIF_ARB_WD_EN
  logic [WD_WIDTH-1:0] wd_cnt;
  logic [WD_WIDTH-1:0] wd_cnt_nxt;
  logic                owner_idle;
`endif

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sel          <= SEL_NONE;
      i2c_active_q <= 1'b0;
      spi_csb_q    <= 1'b1;
`ifdef HIF_ARB_WD_EN
      wd_cnt       <= '0;
`endif
    end else begin
      sel          <= sel_nxt;
      i2c_active_q <= i2c_active;
      spi_csb_q    <= spi_csb;
`ifdef HIF_ARB_WD_EN
      wd_cnt       <= wd_cnt_nxt;
`endif
    end
  end

  // Forced modes win every cycle; auto mode locks on the first activity edge.
  always_comb begin
    sel_nxt = sel;
`ifdef HIF_ARB_WD_EN
    wd_cnt_nxt = '0;
    owner_idle = 1'b0;
`endif
    if (!otp_done) begin
      sel_nxt = SEL_NONE;
    end else if (i2c_if) begin
      sel_nxt = SEL_I2C;
    end else if (spi_if) begin
      sel_nxt = SEL_SPI;
    end else begin
      case (sel)
        SEL_NONE: begin
          if (i2c_rise) begin
            sel_nxt = SEL_I2C;
          end else if (spi_fall) begin
            sel_nxt = SEL_SPI;
          end
        end
        SEL_I2C, SEL_SPI: begin
`ifdef HIF_ARB_WD_EN
          owner_idle = (sel == SEL_I2C) ? ~i2c_active : spi_csb;
          if (owner_idle) begin
            if (wd_cnt == WD_CYCLES - 16'd1) begin
              sel_nxt = SEL_NONE;
            end else begin
              wd_cnt_nxt = wd_cnt + 16'd1;
            end
          end
`endif
        end
        default: sel_nxt = SEL_NONE;
      endcase
    end
  end

endmodule

// File: rtl/hif_xbus_arb.sv
// Host-interface xbus arbiter: sequences I2C/SPI register requests onto the xbus
// with a fixed addr/strobe/ack cycle and address-window check. Option: HIF_ARB_WD_EN.
module hif_xbus_arb
  import hif_xbus_arb_pkg::*;
(
  input  logic                       sys_clk,
  input  logic                       rst_n,
  input  logic                       otp_done,
  input  logic                       testmode_en,
  input  logic                       i2c_if,
  input  logic                       spi_if,
  input  logic                       i2c_active,
  input  logic                       spi_csb,
  input  logic                       i2c_req,
  input  logic                       i2c_wr,
  input  logic [XBUS_ADDR_WIDTH-1:0] i2c_addr,
  input  logic [XBUS_DATA_WIDTH-1:0] i2c_wdata,
  output logic                       i2c_ack,
  output logic [XBUS_DATA_WIDTH-1:0] i2c_rdata,
  input  logic                       spi_req,
  input  logic                       spi_wr,
  input  logic [XBUS_ADDR_WIDTH-1:0] spi_addr,
  input  logic [XBUS_DATA_WIDTH-1:0] spi_wdata,
  output logic                       spi_ack,
  output logic [XBUS_DATA_WIDTH-1:0] spi_rdata,
  output logic [XBUS_ADDR_WIDTH-1:0] xbus_addr,
  output logic                       xbus_wr,
  output logic [XBUS_DATA_WIDTH-1:0] xbus_din,
  input  logic [XBUS_DATA_WIDTH-1:0] xbus_dout,
  output logic [1:0]                 if_select,
  output logic                       hif_idle,
  output logic                       acc_err
);

  logic [1:0] sel;

  hif_sel_fsm u_sel_fsm (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .otp_done   (otp_done),
    .i2c_if     (i2c_if),
    .spi_if     (spi_if),
    .i2c_active (i2c_active),
    .spi_csb    (spi_csb),
    .sel        (sel)
  );

  assign if_select = sel;

  logic                       otp_done_q;
  logic [1:0]                 txn_state;
  logic [1:0]                 txn_state_nxt;
  txn_t                       txn;
  txn_t                       txn_nxt;
  logic [XBUS_ADDR_WIDTH-1:0] xbus_addr_nxt;
  logic [XBUS_DATA_WIDTH-1:0] xbus_din_nxt;
  logic                       xbus_wr_nxt;
  logic                       i2c_ack_nxt;
  logic                       spi_ack_nxt;
  logic [XBUS_DATA_WIDTH-1:0] i2c_rdata_nxt;
  logic [XBUS_DATA_WIDTH-1:0] spi_rdata_nxt;
  logic                       acc_err_nxt;
  logic                       hif_idle_nxt;
  logic                       pick_spi;
  logic                       owner_hit;
  logic                       req_wr;
  logic [XBUS_ADDR_WIDTH-1:0] req_addr;
  logic [XBUS_DATA_WIDTH-1:0] req_wdata;
  logic [XBUS_DATA_WIDTH-1:0] xfer_rdata;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      otp_done_q <= 1'b0;
      txn_state  <= T_IDLE;
      txn        <= '0;
      xbus_addr  <= '0;
      xbus_din   <= '0;
      xbus_wr    <= 1'b0;
      i2c_ack    <= 1'b0;
      spi_ack    <= 1'b0;
      i2c_rdata  <= '0;
      spi_rdata  <= '0;
      acc_err    <= 1'b0;
      hif_idle   <= 1'b1;
    end else begin
      otp_done_q <= otp_done;
      txn_state  <= txn_state_nxt;
      txn        <= txn_nxt;
      xbus_addr  <= xbus_addr_nxt;
      xbus_din   <= xbus_din_nxt;
      xbus_wr    <= xbus_wr_nxt;
      i2c_ack    <= i2c_ack_nxt;
      spi_ack    <= spi_ack_nxt;
      i2c_rdata  <= i2c_rdata_nxt;
      spi_rdata  <= spi_rdata_nxt;
      acc_err    <= acc_err_nxt;
      hif_idle   <= hif_idle_nxt;
    end
  end

  // Owner request wins; otherwise I2C is taken first and rejected as a non-owner.
  always_comb begin
    pick_spi  = 1'b0;
    owner_hit = 1'b0;
    if ((sel == SEL_SPI) && spi_req) begin
      pick_spi  = 1'b1;
      owner_hit = 1'b1;
    end else if ((sel == SEL_I2C) && i2c_req) begin
      owner_hit = 1'b1;
    end else begin
      pick_spi = ~i2c_req;
    end
    req_wr    = pick_spi ? spi_wr    : i2c_wr;
    req_addr  = pick_spi ? spi_addr  : i2c_addr;
    req_wdata = pick_spi ? spi_wdata : i2c_wdata;
  end

  assign xfer_rdata = (txn.legal && !txn.wr) ? xbus_dout : 8'h00;

  // Transaction sequencer; otp_done_q lets the select FSM settle before the first grant.
  always_comb begin
    txn_state_nxt = txn_state;
    txn_nxt       = txn;
    xbus_addr_nxt = xbus_addr;
    xbus_din_nxt  = xbus_din;
    xbus_wr_nxt   = 1'b0;
    i2c_ack_nxt   = 1'b0;
    spi_ack_nxt   = 1'b0;
    i2c_rdata_nxt = i2c_rdata;
    spi_rdata_nxt = spi_rdata;
    acc_err_nxt   = 1'b0;
    case (txn_state)
      T_IDLE: begin
        if (otp_done_q && (i2c_req || spi_req)) begin
          txn_nxt.spi   = pick_spi;
          txn_nxt.wr    = req_wr;
          txn_nxt.addr  = req_addr;
          txn_nxt.wdata = req_wdata;
          txn_nxt.legal = owner_hit && addr_legal(req_addr, testmode_en);
          if (owner_hit) begin
            txn_state_nxt = T_ADDR;
            if (txn_nxt.legal) begin
              xbus_addr_nxt = req_addr;
              xbus_din_nxt  = req_wdata;
            end
          end else begin
            // Non-owner access never reaches the xbus.
            txn_state_nxt = T_ACK;
            acc_err_nxt   = 1'b1;
            if (pick_spi) begin
              spi_ack_nxt   = 1'b1;
              spi_rdata_nxt = 8'h00;
            end else begin
              i2c_ack_nxt   = 1'b1;
              i2c_rdata_nxt = 8'h00;
            end
          end
        end
      end
      T_ADDR: begin
        txn_state_nxt = T_XFER;
        xbus_wr_nxt   = txn.wr & txn.legal;
      end
      T_XFER: begin
        txn_state_nxt = T_ACK;
        acc_err_nxt   = ~txn.legal;
        if (txn.spi) begin
          spi_ack_nxt   = 1'b1;
          spi_rdata_nxt = xfer_rdata;
        end else begin
          i2c_ack_nxt   = 1'b1;
          i2c_rdata_nxt = xfer_rdata;
        end
      end
      default: txn_state_nxt = T_IDLE;
    endcase
    hif_idle_nxt = (txn_state_nxt == T_IDLE) & ~i2c_active & spi_csb;
  end

endmodule

// File: tb/tb_hif_xbus_arb.sv
// Randomised scoreboard bench for hif_xbus_arb against a window/ownership reference model.
module tb_hif_xbus_arb;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic       otp_done, testmode_en, i2c_if, spi_if, i2c_active, spi_csb;
  logic       i2c_req, i2c_wr, spi_req, spi_wr;
  logic [6:0] i2c_addr, spi_addr, xbus_addr;
  logic [7:0] i2c_wdata, spi_wdata, i2c_rdata, spi_rdata, xbus_din, xbus_dout;
  logic       i2c_ack, spi_ack, xbus_wr, hif_idle, acc_err;
  logic [1:0] if_select;

  hif_xbus_arb dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .otp_done(otp_done), .testmode_en(testmode_en),
    .i2c_if(i2c_if), .spi_if(spi_if), .i2c_active(i2c_active), .spi_csb(spi_csb),
    .i2c_req(i2c_req), .i2c_wr(i2c_wr), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata),
    .i2c_ack(i2c_ack), .i2c_rdata(i2c_rdata),
    .spi_req(spi_req), .spi_wr(spi_wr), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_ack(spi_ack), .spi_rdata(spi_rdata),
    .xbus_addr(xbus_addr), .xbus_wr(xbus_wr), .xbus_din(xbus_din), .xbus_dout(xbus_dout),
    .if_select(if_select), .hif_idle(hif_idle), .acc_err(acc_err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    bit         spi;
    logic [7:0] rd;
    bit         err;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         exp_owner = 0;  // 0 none, 1 I2C, 2 SPI
  logic [7:0] regs [128];
  logic [7:0] model_mem [128];

  assign xbus_dout = regs[xbus_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Register file the DUT talks to; the reference model keeps its own copy.
  initial begin
    for (int i = 0; i < 128; i++) begin
      regs[i]      = 8'($urandom);
      model_mem[i] = regs[i];
    end
    forever begin
      @(posedge sys_clk);
      if (xbus_wr) regs[xbus_addr] = xbus_din;
    end
  end

  // Scoreboard monitor: every ack must match the oldest expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (rst_n === 1'b1) begin
        if (acc_err && !(i2c_ack || spi_ack)) check("acc_err_without_ack", 32'(acc_err), 32'd0);
        if (i2c_ack || spi_ack) begin
          check("dual_ack", 32'(i2c_ack & spi_ack), 32'd0);
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_ack: got i2c=%0b spi=%0b required none", i2c_ack, spi_ack);
          end else begin
            e = sb_q.pop_front();
            check("ack_port", 32'(spi_ack), 32'(e.spi));
            check("rdata", 32'(spi_ack ? spi_rdata : i2c_rdata), 32'(e.rd));
            check("acc_err", 32'(acc_err), 32'(e.err));
          end
        end
      end
    end
  end

  task automatic drive_req(input bit spi, input bit val, input bit wr,
                           input logic [6:0] addr, input logic [7:0] data);
    if (spi) begin
      spi_req = val; spi_wr = wr; spi_addr = addr; spi_wdata = data;
    end else begin
      i2c_req = val; i2c_wr = wr; i2c_addr = addr; i2c_wdata = data;
    end
  endtask

  // One request: the model predicts ownership, window legality, latency and read data.
  task automatic do_txn(input bit spi, input bit wr, input logic [6:0] addr, input logic [7:0] data);
    bit   owner_ok, legal;
    int   lat_exp, got_lat, wr_cnt, wr_cyc, limit;
    exp_t e;
    @(posedge sys_clk); #1;
    owner_ok = (spi && exp_owner == 2) || (!spi && exp_owner == 1);
    limit    = testmode_en ? 101 : 100;
    legal    = owner_ok && (int'(addr) <= limit);
    lat_exp  = owner_ok ? 3 : 1;
    e.spi = spi;
    e.err = !legal;
    e.rd  = (legal && !wr) ? model_mem[addr] : 8'h00;
    if (legal && wr) model_mem[addr] = data;
    sb_q.push_back(e);
    drive_req(spi, 1'b1, wr, addr, data);
    got_lat = 0; wr_cnt = 0; wr_cyc = 0;
    for (int k = 1; k <= 8 && got_lat == 0; k++) begin
      @(posedge sys_clk); #1;
      if (xbus_wr) begin wr_cnt++; wr_cyc = k; end
      if (k == 1 && legal) begin
        check("xbus_addr_n1", 32'(xbus_addr), 32'(addr));
        if (wr) check("xbus_din_n1", 32'(xbus_din), 32'(data));
      end
      if (i2c_ack || spi_ack) begin
        got_lat = k;
        drive_req(spi, 1'b0, wr, addr, data);
      end
    end
    if (got_lat == 0) drive_req(spi, 1'b0, wr, addr, data);
    check("ack_latency", 32'(got_lat), 32'(lat_exp));
    check("xbus_wr_count", 32'(wr_cnt), (legal && wr) ? 32'd1 : 32'd0);
    if (legal && wr) check("xbus_wr_cycle", 32'(wr_cyc), 32'd2);
  endtask

  function automatic logic [6:0] pick_addr();
    logic [6:0] pool [8];
    pool = '{7'h05, 7'h12, 7'h30, 7'h63, 7'h64, 7'h65, 7'h66, 7'h7F};
    if ($urandom_range(0, 4) == 0) return 7'($urandom);
    return pool[$urandom_range(0, 7)];
  endfunction

  task automatic random_txns(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk); #1;
      testmode_en = 1'($urandom);
      do_txn(1'($urandom), 1'($urandom), pick_addr(), 8'($urandom));
    end
  endtask

  initial begin
    int   lat;
    exp_t e;
    rst_n = 1'b0; otp_done = 1'b0; testmode_en = 1'b0; i2c_if = 1'b0; spi_if = 1'b0;
    i2c_active = 1'b0; spi_csb = 1'b1;
    i2c_req = 1'b0; i2c_wr = 1'b0; i2c_addr = '0; i2c_wdata = '0;
    spi_req = 1'b0; spi_wr = 1'b0; spi_addr = '0; spi_wdata = '0;
    repeat (2) @(posedge sys_clk);
    #1;
    check("rst_xbus_addr", 32'(xbus_addr), 32'd0);
    check("rst_xbus_din", 32'(xbus_din), 32'd0);
    check("rst_xbus_wr", 32'(xbus_wr), 32'd0);
    check("rst_acks", 32'({i2c_ack, spi_ack, acc_err}), 32'd0);
    check("rst_rdata", 32'({i2c_rdata, spi_rdata}), 32'd0);
    check("rst_if_select", 32'(if_select), 32'd0);
    check("rst_hif_idle", 32'(hif_idle), 32'd1);
    rst_n = 1'b1;

    // No grants before OTP load completes.
    drive_req(1'b0, 1'b1, 1'b0, 7'h05, 8'h00);
    lat = 0;
    repeat (6) begin @(posedge sys_clk); #1; if (i2c_ack) lat++; end
    check("otp_no_ack", 32'(lat), 32'd0);
    check("otp_if_select", 32'(if_select), 32'd0);
    e.spi = 1'b0; e.rd = model_mem[5]; e.err = 1'b0;
    sb_q.push_back(e);
    exp_owner = 1;
    otp_done = 1'b1; i2c_active = 1'b1;
    lat = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(posedge sys_clk); #1;
      if (k == 1) check("otp_lock_i2c", 32'(if_select), 32'd1);
      if (i2c_ack) begin lat = k; i2c_req = 1'b0; end
    end
    if (lat == 0) i2c_req = 1'b0;
    check("otp_ack_in_time", 32'(lat >= 3 && lat <= 4), 32'd1);

    // Directed owner write/readback, non-owner reject, window boundaries.
    do_txn(1'b0, 1'b1, 7'h12, 8'hA5);
    do_txn(1'b0, 1'b0, 7'h12, 8'h00);
    do_txn(1'b1, 1'b0, 7'h05, 8'h00);
    testmode_en = 1'b0;
    do_txn(1'b0, 1'b1, 7'h65, 8'h3C);
    do_txn(1'b0, 1'b1, 7'h66, 8'h3D);
    testmode_en = 1'b1;
    do_txn(1'b0, 1'b1, 7'h65, 8'h3E);
    do_txn(1'b0, 1'b0, 7'h65, 8'h00);
    do_txn(1'b0, 1'b1, 7'h66, 8'h3F);
    random_txns(30);

    // Forced SPI, then both forced (I2C wins), then auto keeps the current lock.
    @(posedge sys_clk); #1; spi_if = 1'b1;
    @(posedge sys_clk); #1;
    check("forced_spi", 32'(if_select), 32'd2);
    exp_owner = 2;
    random_txns(20);
    @(posedge sys_clk); #1; i2c_if = 1'b1;
    @(posedge sys_clk); #1;
    check("forced_both", 32'(if_select), 32'd1);
    exp_owner = 1;
    random_txns(6);
    @(posedge sys_clk); #1; i2c_if = 1'b0; spi_if = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("auto_hold", 32'(if_select), 32'd1);

    // Simultaneous I2C rise / SPI fall after reset locks I2C.
    rst_n = 1'b0; i2c_active = 1'b0; spi_csb = 1'b1; exp_owner = 0;
    repeat (2) @(posedge sys_clk);
    #1; rst_n = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    check("idle_quiet", 32'(hif_idle), 32'd1);
    check("none_after_rst", 32'(if_select), 32'd0);
    i2c_active = 1'b1; spi_csb = 1'b0;
    @(posedge sys_clk); #1;
    check("tie_lock_i2c", 32'(if_select), 32'd1);
    exp_owner = 1;
    @(posedge sys_clk); #1;
    check("idle_busy", 32'(hif_idle), 32'd0);
    spi_csb = 1'b1;
    do_txn(1'b0, 1'b1, 7'h30, 8'h5A);
    do_txn(1'b1, 1'b1, 7'h30, 8'h77);

`ifdef HIF_ARB_WD_EN
    i2c_active = 1'b0;
    repeat (990) @(posedge sys_clk);
    #1;
    check("wd_not_yet", 32'(if_select), 32'd1);
    repeat (20) @(posedge sys_clk);
    #1;
    check("wd_release", 32'(if_select), 32'd0);
    i2c_active = 1'b1;
    @(posedge sys_clk); #1;
    exp_owner = 1;
`endif

    // Async reset during the write strobe aborts without an ack.
    @(posedge sys_clk); #1;
    drive_req(1'b0, 1'b1, 1'b1, 7'h12, 8'hC3);
    repeat (2) @(posedge sys_clk);
    #1;
    check("abort_wr_pre", 32'(xbus_wr), 32'd1);
    rst_n = 1'b0; i2c_active = 1'b0;
    #1;
    check("abort_wr_async", 32'(xbus_wr), 32'd0);
    check("abort_no_ack", 32'({i2c_ack, spi_ack}), 32'd0);
    i2c_req = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1; rst_n = 1'b1; exp_owner = 0;
    repeat (5) @(posedge sys_clk);
    #1;
    check("abort_regs_untouched", 32'(regs[7'h12]), 32'(model_mem[7'h12]));
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
